zfb_mem_ctrl: RTL and testbench
===============================

Name: zfb_mem_ctrl

Overview:
- Synthesizable replacement for the behavioural frame-buffer/z-buffer model used in simulation.
- Holds a PIX_W frame buffer and a Z_W depth buffer of WIDTH*HEIGHT entries.
- Serves the rasterizer's Z read port (1-cycle sync read), its Z write port and its FB write port, plus a scan-out read port.
- Adds a hardware clear engine that fills both buffers with background colour and far-plane depth before each frame. Sits between fpga_top's rasterizer and the display path.

Parameters:
- WIDTH, 320, pixels per row
- HEIGHT, 240, rows
- ADDR_W, 17, address width; must satisfy 2**ADDR_W >= WIDTH*HEIGHT
- PIX_W, 12, pixel width (4R/4G/4B at default)
- Z_W, 8, depth width
- CLEAR_PIX, 12'h000, background pixel written by clear
- CLEAR_Z, all ones, far-plane depth written by clear

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- i_clear_start  in  1  one-cycle request to clear both buffers
- o_clear_busy  out  1  clear in progress
- o_clear_done  out  1  one-cycle pulse when clear completes
- i_zb_r_addr  in  ADDR_W  Z read address
- o_zb_r_data  out  Z_W  Z read data, 1 cycle after address
- i_zb_w_addr  in  ADDR_W  Z write address
- i_zb_we  in  1  Z write enable
- i_zb_w_data  in  Z_W  Z write data
- i_fb_addr  in  ADDR_W  FB write address
- i_fb_we  in  1  FB write enable
- i_fb_pixel  in  PIX_W  FB write data
- i_scan_addr  in  ADDR_W  scan-out read address
- i_scan_re  in  1  scan-out read enable
- o_scan_pixel  out  PIX_W  scan-out data
- o_scan_valid  out  1  o_scan_pixel valid, 1 cycle after i_scan_re
- o_fb_write_count  out  32  accepted FB writes since last clear (see Optional Feature)

Behaviour:
- DEPTH = WIDTH*HEIGHT. Memory contents are not reset.
- Reset values (rst_n low): FSM=IDLE, clear counter=0, o_clear_busy=0, o_clear_done=0, o_zb_r_data=CLEAR_Z, o_scan_pixel=0, o_scan_valid=0, o_fb_write_count=0.
- FSM states:
  - IDLE: i_clear_start -> CLEAR, counter=0, o_clear_busy=1 from the next cycle.
  - CLEAR: each cycle writes FB[counter]=CLEAR_PIX and ZB[counter]=CLEAR_Z, then counter++. At counter==DEPTH-1 the write happens and the FSM goes to DONE.
  - DONE: o_clear_done=1 for exactly one cycle, o_clear_busy=0, FSM -> IDLE.
- Clear latency: start sampled at cycle 0; busy on cycles 1..DEPTH; done pulse on cycle DEPTH+1.
- i_clear_start while busy or in DONE is ignored; no restart.
- During CLEAR, i_zb_we and i_fb_we are dropped and o_fb_write_count does not change. Z reads return CLEAR_Z. Scan reads still operate and return the current memory contents.
- Z read: o_zb_r_data <= ZB[i_zb_r_addr] every cycle, with no enable.
- Z read/write collision: if i_zb_we is high and i_zb_w_addr==i_zb_r_addr in the same cycle, the next o_zb_r_data is i_zb_w_data (write-first bypass).
- Simultaneous FB and Z writes are independent and both are accepted in one cycle.
- Out-of-range address (>= DEPTH):
  - writes are dropped;
  - Z read returns CLEAR_Z;
  - scan read returns CLEAR_PIX with o_scan_valid still 1.
- Scan port: o_scan_valid <= i_scan_re. o_scan_pixel updates only when i_scan_re is high and otherwise holds.
- Reset mid-clear aborts the clear: FSM=IDLE, busy=0, no done pulse. Partially cleared contents are left as they are.

Optional Feature:
- Macro ZFB_WRITE_COUNT_EN.
- Defined: o_fb_write_count increments by 1 on every accepted FB write (in-range, not clearing) and resets to 0 when a clear enters CLEAR. It saturates at 32'hFFFF_FFFF.
- Undefined: o_fb_write_count is tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset, pulse i_clear_start -> busy high for 76800 cycles, done pulse at cycle 76801. Z read at 0, 38400 and 76799 returns 8'hFF; scan reads at the same addresses return 12'h000.
- After clear, FB write addr 1000 pixel 12'hF0A and Z write addr 1000 data 8'h40 -> Z read addr 1000 returns 8'h40 next cycle; scan addr 1000 returns 12'hF0A with valid.
- Same-cycle Z write addr 500 data 8'h12 and Z read addr 500 -> o_zb_r_data=8'h12 on the following cycle.
- FB write addr 200 data 12'h123 issued during CLEAR, then clear completes -> scan addr 200 returns 12'h000. A second i_clear_start while busy does not extend busy.
- Write to addr 76800 and 131071 -> no memory change. Z read at 76800 returns 8'hFF; scan read returns 12'h000 with valid=1.
- With ZFB_WRITE_COUNT_EN: clear, then 3 FB writes in range plus 1 out of range -> count=3; a new clear resets it to 0. Reset asserted at clear cycle 100 -> busy drops immediately and no done pulse occurs.

Source files
------------

// File: rtl/zfb_mem_ctrl.sv
// zfb_mem_ctrl: frame-buffer / z-buffer memory controller with a hardware
// clear engine. Serves the rasterizer Z read/write and FB write ports and a
// scan-out read port. Optional FB write counter is built when the macro
// ZFB_WRITE_COUNT_EN is defined; otherwise o_fb_write_count is tied to 0.
module zfb_mem_ctrl #(
  parameter int               WIDTH     = 320,
  parameter int               HEIGHT    = 240,
  parameter int               ADDR_W    = 17,
  parameter int               PIX_W     = 12,
  parameter int               Z_W       = 8,
  parameter logic [PIX_W-1:0] CLEAR_PIX = '0,
  parameter logic [Z_W-1:0]   CLEAR_Z   = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear_start,
  output logic              o_clear_busy,
  output logic              o_clear_done,
  input  logic [ADDR_W-1:0] i_zb_r_addr,
  output logic [Z_W-1:0]    o_zb_r_data,
  input  logic [ADDR_W-1:0] i_zb_w_addr,
  input  logic              i_zb_we,
  input  logic [Z_W-1:0]    i_zb_w_data,
  input  logic [ADDR_W-1:0] i_fb_addr,
  input  logic              i_fb_we,
  input  logic [PIX_W-1:0]  i_fb_pixel,
  input  logic [ADDR_W-1:0] i_scan_addr,
  input  logic              i_scan_re,
  output logic [PIX_W-1:0]  o_scan_pixel,
  output logic              o_scan_valid,
  output logic [31:0]       o_fb_write_count
);

  localparam int DEPTH = WIDTH * HEIGHT;
  // One extra bit so the bound stays correct when 2**ADDR_W == DEPTH.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  logic [PIX_W-1:0]  r_fb [DEPTH];
  logic [Z_W-1:0]    r_zb [DEPTH];

  logic [Z_W-1:0]    r_zb_rdata;
  logic [PIX_W-1:0]  r_scan_pixel;
  logic              r_scan_valid;

  logic              w_clearing;
  logic              w_clear_go;
  logic              w_fb_ok;
  logic              w_zb_ok;

  function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_X);
  endfunction

  assign w_clearing = (r_state == S_CLEAR);
  assign w_clear_go = (r_state == S_IDLE) && i_clear_start;
  assign w_fb_ok    = i_fb_we && f_in_range(i_fb_addr)   && !w_clearing;
  assign w_zb_ok    = i_zb_we && f_in_range(i_zb_w_addr) && !w_clearing;

  // Clear FSM state and address counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Clear FSM next-state and counter sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (i_clear_start) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      S_CLEAR: begin
        if (r_cnt == LAST_A) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_clear_busy = (r_state == S_CLEAR);
  assign o_clear_done = (r_state == S_DONE);

  // Memory write ports; the clear engine owns both arrays while clearing.
  always_ff @(posedge clk) begin
    if (w_clearing) begin
      r_fb[r_cnt] <= CLEAR_PIX;
      r_zb[r_cnt] <= CLEAR_Z;
    end else begin
      if (w_fb_ok) r_fb[i_fb_addr]   <= i_fb_pixel;
      if (w_zb_ok) r_zb[i_zb_w_addr] <= i_zb_w_data;
    end
  end

  // Z read: every cycle, far-plane while clearing or out of range, write-first bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zb_rdata <= CLEAR_Z;
    end else if (w_clearing || !f_in_range(i_zb_r_addr)) begin
      r_zb_rdata <= CLEAR_Z;
    end else if (w_zb_ok && (i_zb_w_addr == i_zb_r_addr)) begin
      r_zb_rdata <= i_zb_w_data;
    end else begin
      r_zb_rdata <= r_zb[i_zb_r_addr];
    end
  end

  // Scan-out read: data updates only on enable, valid follows enable by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_pixel <= '0;
      r_scan_valid <= 1'b0;
    end else begin
      r_scan_valid <= i_scan_re;
      if (i_scan_re) begin
        if (f_in_range(i_scan_addr)) r_scan_pixel <= r_fb[i_scan_addr];
        else                         r_scan_pixel <= CLEAR_PIX;
      end
    end
  end

  assign o_zb_r_data  = r_zb_rdata;
  assign o_scan_pixel = r_scan_pixel;
  assign o_scan_valid = r_scan_valid;

`ifdef ZFB_WRITE_COUNT_EN
  logic [31:0] r_wr_cnt;

  // Accepted FB write counter, zeroed when a clear begins, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
    end else if (w_clear_go) begin
      r_wr_cnt <= '0;
    end else if (w_fb_ok && (r_wr_cnt != 32'hFFFF_FFFF)) begin
      r_wr_cnt <= r_wr_cnt + 32'd1;
    end
  end

  assign o_fb_write_count = r_wr_cnt;
`else
  assign o_fb_write_count = 32'd0;
`endif

endmodule

// File: tb/tb_zfb_mem_ctrl.sv
// tb_zfb_mem_ctrl: directed self-checking bench for zfb_mem_ctrl at default
// parameters. Expected counter value depends on ZFB_WRITE_COUNT_EN.
module tb_zfb_mem_ctrl;

`ifdef ZFB_WRITE_COUNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_clear_start;
  logic        o_clear_busy;
  logic        o_clear_done;
  logic [16:0] i_zb_r_addr;
  logic [7:0]  o_zb_r_data;
  logic [16:0] i_zb_w_addr;
  logic        i_zb_we;
  logic [7:0]  i_zb_w_data;
  logic [16:0] i_fb_addr;
  logic        i_fb_we;
  logic [11:0] i_fb_pixel;
  logic [16:0] i_scan_addr;
  logic        i_scan_re;
  logic [11:0] o_scan_pixel;
  logic        o_scan_valid;
  logic [31:0] o_fb_write_count;

  int n_assert = 0;
  int n_fail   = 0;

  zfb_mem_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_clear_start    (i_clear_start),
    .o_clear_busy     (o_clear_busy),
    .o_clear_done     (o_clear_done),
    .i_zb_r_addr      (i_zb_r_addr),
    .o_zb_r_data      (o_zb_r_data),
    .i_zb_w_addr      (i_zb_w_addr),
    .i_zb_we          (i_zb_we),
    .i_zb_w_data      (i_zb_w_data),
    .i_fb_addr        (i_fb_addr),
    .i_fb_we          (i_fb_we),
    .i_fb_pixel       (i_fb_pixel),
    .i_scan_addr      (i_scan_addr),
    .i_scan_re        (i_scan_re),
    .o_scan_pixel     (o_scan_pixel),
    .o_scan_valid     (o_scan_valid),
    .o_fb_write_count (o_fb_write_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic read_z(input string tag, input logic [16:0] a, input logic [7:0] exp);
    i_zb_r_addr = a;
    step();
    chk(tag, {24'd0, o_zb_r_data}, {24'd0, exp});
  endtask

  task automatic scan(input string tag, input logic [16:0] a, input logic [11:0] exp);
    i_scan_addr = a;
    i_scan_re   = 1'b1;
    step();
    i_scan_re   = 1'b0;
    chk({tag, "_pix"}, {20'd0, o_scan_pixel}, {20'd0, exp});
    chk({tag, "_vld"}, {31'd0, o_scan_valid}, 32'd1);
  endtask

  task automatic fb_wr(input logic [16:0] a, input logic [11:0] p);
    i_fb_addr  = a;
    i_fb_pixel = p;
    i_fb_we    = 1'b1;
    step();
    i_fb_we    = 1'b0;
  endtask

  initial begin
    int n;
    int seen_done;
    rst_n = 1'b0;
    i_clear_start = 1'b0;
    i_zb_r_addr = '0; i_zb_w_addr = '0; i_zb_we = 1'b0; i_zb_w_data = '0;
    i_fb_addr = '0; i_fb_we = 1'b0; i_fb_pixel = '0;
    i_scan_addr = '0; i_scan_re = 1'b0;

    #12;
    chk("rst_busy",  {31'd0, o_clear_busy}, 32'd0);
    chk("rst_done",  {31'd0, o_clear_done}, 32'd0);
    chk("rst_zdata", {24'd0, o_zb_r_data},  32'hFF);
    chk("rst_spix",  {20'd0, o_scan_pixel}, 32'h0);
    chk("rst_svld",  {31'd0, o_scan_valid}, 32'd0);
    chk("rst_cnt",   o_fb_write_count,      32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Full clear, with a dropped FB write, a Z read and a repeated start inside it
    i_clear_start = 1'b1;
    step();
    i_clear_start = 1'b0;
    chk("busy_c1", {31'd0, o_clear_busy}, 32'd1);
    i_zb_r_addr = 17'd60000;
    n = 0;
    while (o_clear_busy && n < 80000) begin
      i_fb_we       = (n == 300);
      i_fb_addr     = 17'd200;
      i_fb_pixel    = 12'h123;
      i_clear_start = (n == 10);
      step();
      n++;
      if (n == 301) chk("z_during_clear", {24'd0, o_zb_r_data}, 32'hFF);
    end
    i_fb_we = 1'b0;
    i_clear_start = 1'b0;
    chk("busy_len",  n, 32'd76800);
    chk("done_hi",   {31'd0, o_clear_done}, 32'd1);
    step();
    chk("done_1cyc", {31'd0, o_clear_done}, 32'd0);
    chk("busy_idle", {31'd0, o_clear_busy}, 32'd0);
    chk("cnt_after_clear", o_fb_write_count, 32'd0);

    read_z("z0",     17'd0,     8'hFF);
    read_z("z38400", 17'd38400, 8'hFF);
    read_z("z76799", 17'd76799, 8'hFF);
    scan("s0",     17'd0,     12'h000);
    scan("s38400", 17'd38400, 12'h000);
    scan("s76799", 17'd76799, 12'h000);
    scan("s200_dropped", 17'd200, 12'h000);

    // Simultaneous FB and Z write, then read back
    i_fb_addr = 17'd1000; i_fb_pixel = 12'hF0A; i_fb_we = 1'b1;
    i_zb_w_addr = 17'd1000; i_zb_w_data = 8'h40; i_zb_we = 1'b1;
    step();
    i_fb_we = 1'b0; i_zb_we = 1'b0;
    read_z("z1000", 17'd1000, 8'h40);
    scan("s1000", 17'd1000, 12'hF0A);
    i_scan_addr = 17'd0;
    step();
    chk("scan_hold_pix", {20'd0, o_scan_pixel}, 32'hF0A);
    chk("scan_hold_vld", {31'd0, o_scan_valid}, 32'd0);

    // Write-first bypass on Z collision
    i_zb_w_addr = 17'd500; i_zb_w_data = 8'h12; i_zb_we = 1'b1;
    i_zb_r_addr = 17'd500;
    step();
    i_zb_we = 1'b0;
    chk("z_bypass", {24'd0, o_zb_r_data}, 32'h12);
    read_z("z500_mem", 17'd500, 8'h12);

    // Out-of-range writes and reads
    fb_wr(17'd76800, 12'h777);
    fb_wr(17'd131071, 12'h777);
    i_zb_w_addr = 17'd76800; i_zb_w_data = 8'h55; i_zb_we = 1'b1;
    i_zb_r_addr = 17'd76800;
    step();
    i_zb_we = 1'b0;
    chk("z_oor_bypass", {24'd0, o_zb_r_data}, 32'hFF);
    i_zb_w_addr = 17'd131071; i_zb_we = 1'b1;
    step();
    i_zb_we = 1'b0;
    read_z("z76800",  17'd76800,  8'hFF);
    read_z("z131071", 17'd131071, 8'hFF);
    scan("s76800",  17'd76800,  12'h000);
    scan("s131071", 17'd131071, 12'h000);

    // Write counter: addr 1000 plus two more in range, two out of range
    fb_wr(17'd2, 12'h555);
    fb_wr(17'd3, 12'hABC);
    chk("cnt3", o_fb_write_count, CNT_EN * 3);
    scan("s3", 17'd3, 12'hABC);

    // New clear zeroes the counter; reset at clear cycle 100 aborts it
    i_clear_start = 1'b1;
    step();
    i_clear_start = 1'b0;
    chk("busy2_c1", {31'd0, o_clear_busy}, 32'd1);
    chk("cnt_zero", o_fb_write_count, 32'd0);
    for (int i = 0; i < 99; i++) step();
    chk("busy2_c100", {31'd0, o_clear_busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, o_clear_busy}, 32'd0);
    chk("abort_done", {31'd0, o_clear_done}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (o_clear_done) seen_done++;
    end
    chk("no_done_after_abort", seen_done, 32'd0);
    chk("idle_after_abort", {31'd0, o_clear_busy}, 32'd0);
    scan("s3_cleared",   17'd3,    12'h000);
    scan("s1000_intact", 17'd1000, 12'hF0A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
